// File: rtl/eot_release_arbiter.sv
// eot_release_arbiter: two data channels share one output stream.
// A channel is armed by an eot word on its predicate stream. An armed channel
// may then release exactly one data transaction (through its data eot) onto
// dout. Armed channels are served round-robin, and the grant is held for the
// whole transaction. Completed transactions are counted in a wrapping counter.
//
// Handshake semantics on every stream (din0, din1, pred0, pred1, dout): a word
// transfers on a rising edge where valid && ready. A source that raises valid
// holds valid and data stable until that transfer. ready may depend on valid
// only through the registered grant, never through a combinational loop.
module eot_release_arbiter #(
    parameter int W_DIN  = 16,
    parameter int W_PRED = 16,
    parameter int W_CNT  = 8
) (
    input  logic              clk,
    input  logic              rst,
    // data channel 0
    input  logic [W_DIN-1:0]  din0_data,
    input  logic              din0_valid,
    output logic              din0_ready,
    // data channel 1
    input  logic [W_DIN-1:0]  din1_data,
    input  logic              din1_valid,
    output logic              din1_ready,
    // predicate stream for channel 0
    input  logic [W_PRED-1:0] pred0_data,
    input  logic              pred0_valid,
    output logic              pred0_ready,
    // predicate stream for channel 1
    input  logic [W_PRED-1:0] pred1_data,
    input  logic              pred1_valid,
    output logic              pred1_ready,
    // shared output stream
    output logic [W_DIN-1:0]  dout_data,
    output logic              dout_valid,
    input  logic              dout_ready,
    // status
    output logic              dout_sel,
    output logic [W_CNT-1:0]  done_cnt,
    // observation of internal state
    output logic [1:0]        state_dbg,
    output logic [1:0]        armed_dbg,
    output logic              last_dbg
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT0 = 2'd1,
        GRANT1 = 2'd2
    } state_t;

    state_t           state;
    logic             armed0;
    logic             armed1;
    logic             last;
    logic [W_CNT-1:0] cnt;

    logic             pred0_eot;
    logic             pred1_eot;
    logic             data_eot;
    logic             unused_pred_bits;

    // Only the eot flag of a predicate word matters; the rest is discarded.
    assign unused_pred_bits = ^{pred0_data[W_PRED-2:0], pred1_data[W_PRED-2:0]};

    // An armed channel stops listening to its predicate stream until released.
    assign pred0_ready = !armed0;
    assign pred1_ready = !armed1;

    assign pred0_eot = pred0_valid && !armed0 && pred0_data[W_PRED-1];
    assign pred1_eot = pred1_valid && !armed1 && pred1_data[W_PRED-1];

    // Zero-latency output mux steered only by the registered grant.
    always_comb begin
        dout_valid = 1'b0;
        dout_data  = '0;
        din0_ready = 1'b0;
        din1_ready = 1'b0;
        dout_sel   = 1'b0;
        case (state)
            GRANT0: begin
                dout_valid = din0_valid;
                dout_data  = din0_data;
                din0_ready = dout_ready;
                dout_sel   = 1'b0;
            end
            GRANT1: begin
                dout_valid = din1_valid;
                dout_data  = din1_data;
                din1_ready = dout_ready;
                dout_sel   = 1'b1;
            end
            default: begin
                dout_valid = 1'b0;
            end
        endcase
    end

    // The last word of the granted transaction leaves this cycle.
    assign data_eot = dout_valid && dout_ready && dout_data[W_DIN-1];

    // Arming flags, round-robin pointer, grant FSM and completion counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            armed0 <= 1'b0;
            armed1 <= 1'b0;
            last   <= 1'b1;
            cnt    <= '0;
        end else begin
            // A granted channel is always armed, so its predicate stream is
            // stalled and a set here never coincides with its own release.
            if (pred0_eot) begin
                armed0 <= 1'b1;
            end
            if (pred1_eot) begin
                armed1 <= 1'b1;
            end
            case (state)
                IDLE: begin
                    // Arming registered last cycle is what makes a channel
                    // eligible; a tie goes to the channel not served last.
                    if (armed0 && armed1) begin
                        state <= last ? GRANT0 : GRANT1;
                    end else if (armed0) begin
                        state <= GRANT0;
                    end else if (armed1) begin
                        state <= GRANT1;
                    end
                end
                GRANT0: begin
                    if (data_eot) begin
                        armed0 <= 1'b0;
                        last   <= 1'b0;
                        cnt    <= cnt + W_CNT'(1);
                        // Hand over directly, even to an arming seen this cycle.
                        state  <= (armed1 || pred1_eot) ? GRANT1 : IDLE;
                    end
                end
                GRANT1: begin
                    if (data_eot) begin
                        armed1 <= 1'b0;
                        last   <= 1'b1;
                        cnt    <= cnt + W_CNT'(1);
                        state  <= (armed0 || pred0_eot) ? GRANT0 : IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign done_cnt  = cnt;
    assign state_dbg = state;
    assign armed_dbg = {armed1, armed0};
    assign last_dbg  = last;

endmodule

// File: tb/tb_eot_release_arbiter.sv
// Bench for eot_release_arbiter: directed scenarios with literal expectations,
// a per-cycle behavioural model and an expected-word queue on dout.
module tb_eot_release_arbiter;

    localparam int W_DIN  = 16;
    localparam int W_PRED = 16;
    localparam int W_CNT  = 2;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [W_DIN-1:0]  din0_data = '0;
    logic              din0_valid = 1'b0;
    logic              din0_ready;
    logic [W_DIN-1:0]  din1_data = '0;
    logic              din1_valid = 1'b0;
    logic              din1_ready;
    logic [W_PRED-1:0] pred0_data = '0;
    logic              pred0_valid = 1'b0;
    logic              pred0_ready;
    logic [W_PRED-1:0] pred1_data = '0;
    logic              pred1_valid = 1'b0;
    logic              pred1_ready;
    logic [W_DIN-1:0]  dout_data;
    logic              dout_valid;
    logic              dout_ready = 1'b0;
    logic              dout_sel;
    logic [W_CNT-1:0]  done_cnt;
    logic [1:0]        state_dbg;
    logic [1:0]        armed_dbg;
    logic              last_dbg;

    eot_release_arbiter #(
        .W_DIN (W_DIN),
        .W_PRED(W_PRED),
        .W_CNT (W_CNT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .din0_data  (din0_data),
        .din0_valid (din0_valid),
        .din0_ready (din0_ready),
        .din1_data  (din1_data),
        .din1_valid (din1_valid),
        .din1_ready (din1_ready),
        .pred0_data (pred0_data),
        .pred0_valid(pred0_valid),
        .pred0_ready(pred0_ready),
        .pred1_data (pred1_data),
        .pred1_valid(pred1_valid),
        .pred1_ready(pred1_ready),
        .dout_data  (dout_data),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .dout_sel   (dout_sel),
        .done_cnt   (done_cnt),
        .state_dbg  (state_dbg),
        .armed_dbg  (armed_dbg),
        .last_dbg   (last_dbg)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- bookkeeping ----------------
    int checks = 0;
    int errors = 0;
    logic [W_DIN:0]   exp_q[$];   // {dout_sel, dout_data} in expected order
    logic [W_DIN-1:0] tx0[$];
    logic [W_DIN-1:0] tx1[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // ---------------- behavioural model + compare ----------------
    // m_owner: channel currently holding the stream, -1 when nobody does.
    int   m_owner;
    bit   m_armed[2];
    int   m_last;
    int   m_cnt;
    logic hold_pending;
    logic [W_DIN-1:0] hold_data;

    always @(negedge clk) begin
        logic [W_DIN-1:0]  dd[2];
        logic [W_PRED-1:0] pd[2];
        logic              dv[2];
        logic              pv[2];
        logic              e_valid;
        logic [W_DIN-1:0]  e_data;
        bit                nxt[2];
        int                other;
        dd[0] = din0_data;  dd[1] = din1_data;
        dv[0] = din0_valid; dv[1] = din1_valid;
        pd[0] = pred0_data; pd[1] = pred1_data;
        pv[0] = pred0_valid; pv[1] = pred1_valid;
        if (!rst) begin
            m_owner = -1;
            m_armed = '{1'b0, 1'b0};
            m_last = 1;
            m_cnt = 0;
            hold_pending = 1'b0;
            check("rst_dout_valid", dout_valid, 0);
            check("rst_din0_ready", din0_ready, 0);
            check("rst_din1_ready", din1_ready, 0);
            check("rst_pred0_ready", pred0_ready, 1);
            check("rst_pred1_ready", pred1_ready, 1);
            check("rst_dout_sel", dout_sel, 0);
            check("rst_done_cnt", done_cnt, 0);
        end else begin
            e_valid = (m_owner >= 0) ? dv[m_owner] : 1'b0;
            e_data  = (m_owner >= 0) ? dd[m_owner] : '0;
            check("m_dout_valid", dout_valid, e_valid);
            if (e_valid) check("m_dout_data", dout_data, e_data);
            check("m_dout_sel", dout_sel, (m_owner == 1));
            check("m_din0_ready", din0_ready, (m_owner == 0) && dout_ready);
            check("m_din1_ready", din1_ready, (m_owner == 1) && dout_ready);
            check("m_pred0_ready", pred0_ready, !m_armed[0]);
            check("m_pred1_ready", pred1_ready, !m_armed[1]);
            check("m_done_cnt", done_cnt, m_cnt);
            check("m_armed", armed_dbg, {m_armed[1], m_armed[0]});
            // a stalled word must still be there, unchanged
            if (hold_pending) begin
                check("hold_valid", dout_valid, 1);
                check("hold_data", dout_data, hold_data);
            end
            hold_pending = dout_valid && !dout_ready;
            hold_data = dout_data;
            // scoreboard on dout transfers
            if (dout_valid && dout_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_unexpected: got sel=%0d data=0x%0h, expected no word", dout_sel, dout_data);
                end else begin
                    check("sb_word", {dout_sel, dout_data}, exp_q.pop_front());
                end
            end
            // advance the model to the state after the coming edge
            for (int i = 0; i < 2; i++) nxt[i] = m_armed[i] || (pv[i] && !m_armed[i] && pd[i][W_PRED-1]);
            if (m_owner >= 0 && e_valid && dout_ready && e_data[W_DIN-1]) begin
                nxt[m_owner] = 1'b0;
                m_last = m_owner;
                m_cnt = (m_cnt + 1) % (1 << W_CNT);
                other = 1 - m_owner;
                m_owner = nxt[other] ? other : -1;
            end else if (m_owner < 0) begin
                if (m_armed[0] && m_armed[1]) m_owner = 1 - m_last;
                else if (m_armed[0]) m_owner = 0;
                else if (m_armed[1]) m_owner = 1;
            end
            m_armed = nxt;
        end
    end

    // ---------------- drivers ----------------
    task automatic drive_din(input int ch);
        logic [W_DIN-1:0] w;
        logic hs;
        int n;
        while ((ch == 0) ? (tx0.size() > 0) : (tx1.size() > 0)) begin
            w = (ch == 0) ? tx0[0] : tx1[0];
            if (ch == 0) begin din0_valid = 1'b1; din0_data = w; end
            else begin din1_valid = 1'b1; din1_data = w; end
            hs = 1'b0;
            n = 0;
            while (!hs && n < 100) begin
                @(negedge clk);
                hs = (ch == 0) ? din0_ready : din1_ready;
                @(posedge clk);
                #1;
                n++;
            end
            if (!hs) begin
                checks++;
                errors++;
                $display("FAIL din%0d_timeout: word 0x%0h got no ready, expected a handshake within 100 cycles", ch, w);
                break;
            end
            if (ch == 0) void'(tx0.pop_front());
            else void'(tx1.pop_front());
        end
        if (ch == 0) din0_valid = 1'b0;
        else din1_valid = 1'b0;
    endtask

    task automatic send_pred(input int ch, input logic [W_PRED-1:0] w);
        logic r;
        int n;
        r = 1'b0;
        n = 0;
        if (ch == 0) begin pred0_valid = 1'b1; pred0_data = w; end
        else begin pred1_valid = 1'b1; pred1_data = w; end
        while (!r && n < 100) begin
            @(negedge clk);
            r = (ch == 0) ? pred0_ready : pred1_ready;
            @(posedge clk);
            #1;
            n++;
        end
        if (!r) begin
            checks++;
            errors++;
            $display("FAIL pred%0d_timeout: got no ready, expected a handshake within 100 cycles", ch);
        end
        if (ch == 0) pred0_valid = 1'b0;
        else pred1_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        din0_valid = 1'b0; din1_valid = 1'b0;
        pred0_valid = 1'b0; pred1_valid = 1'b0;
        dout_ready = 1'b0;
        tx0.delete(); tx1.delete(); exp_q.delete();
        cyc(2);
        rst = 1'b1;
        cyc(1);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #200000;
        errors++;
        $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // literal expectations for the tie scenario, one entry per cycle t+1..t+6
    bit               t3_valid[6];
    bit               t3_sel[6];
    logic [W_DIN-1:0] t3_data[6];
    int               t3_cnt[2];
    int               wrap_cnt[5];

    // ---------------- directed scenarios ----------------
    initial begin
        // reset, with a data word and a ready consumer present
        din0_valid = 1'b1; din0_data = 16'h8abc; dout_ready = 1'b1;
        cyc(2);
        @(negedge clk);
        check("reset_dout_valid", dout_valid, 0);
        check("reset_din0_ready", din0_ready, 0);
        check("reset_pred0_ready", pred0_ready, 1);
        check("reset_state", state_dbg, 0);
        check("reset_last", last_dbg, 1);
        check("reset_armed", armed_dbg, 0);
        check("reset_done_cnt", done_cnt, 0);
        @(posedge clk); #1;
        din0_valid = 1'b0;
        rst = 1'b1;
        cyc(1);

        // 1: single channel, arming latency
        exp_q.push_back({1'b0, 16'h0011});
        exp_q.push_back({1'b0, 16'h8022});
        din0_valid = 1'b1; din0_data = 16'h0011; dout_ready = 1'b1;
        pred0_valid = 1'b1; pred0_data = 16'h0001;
        cyc(1);
        pred0_data = 16'h8000;
        cyc(1);
        pred0_valid = 1'b0;
        @(negedge clk);
        check("t1_no_valid_t+1", dout_valid, 0);
        check("t1_pred0_stalled", pred0_ready, 0);
        @(posedge clk); #1;
        @(negedge clk);
        check("t1_valid_t+2", dout_valid, 1);
        check("t1_word0", dout_data, 16'h0011);
        check("t1_sel", dout_sel, 0);
        @(posedge clk); #1;
        din0_data = 16'h8022;
        @(negedge clk);
        check("t1_word1", dout_data, 16'h8022);
        check("t1_cnt_before", done_cnt, 0);
        @(posedge clk); #1;
        din0_valid = 1'b0;
        @(negedge clk);
        check("t1_done_cnt", done_cnt, 1);
        check("t1_pred0_ready_back", pred0_ready, 1);
        check("t1_idle", dout_valid, 0);
        @(posedge clk); #1;

        // 2: gate closed on an unarmed channel
        din1_valid = 1'b1; din1_data = 16'h1234;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("t2_dout_valid", dout_valid, 0);
            check("t2_din1_ready", din1_ready, 0);
            @(posedge clk); #1;
        end
        din1_valid = 1'b0;
        cyc(1);

        // 3: tie and round-robin handover, twice
        do_reset();
        dout_ready = 1'b1;
        t3_cnt = '{2, 0};
        for (int r = 0; r < 2; r++) begin
            t3_valid = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
            t3_sel   = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
            t3_data  = '{16'h0000, 16'h0100 + 16'(r), 16'h8101 + 16'(r),
                         16'h0200 + 16'(r), 16'h8201 + 16'(r), 16'h0000};
            for (int k = 1; k < 5; k++) begin
                tx0.push_back(16'h0);
            end
            tx0.delete();
            tx0.push_back(t3_data[1]); tx0.push_back(t3_data[2]);
            tx1.push_back(t3_data[3]); tx1.push_back(t3_data[4]);
            for (int k = 1; k < 5; k++) exp_q.push_back({t3_sel[k], t3_data[k]});
            pred0_valid = 1'b1; pred0_data = 16'h8000;
            pred1_valid = 1'b1; pred1_data = 16'h8000;
            cyc(1);
            pred0_valid = 1'b0; pred1_valid = 1'b0;
            fork
                drive_din(0);
                drive_din(1);
                begin
                    for (int k = 0; k < 6; k++) begin
                        @(negedge clk);
                        check("t3_valid", dout_valid, t3_valid[k]);
                        check("t3_sel", dout_sel, t3_sel[k]);
                        if (t3_valid[k]) check("t3_data", dout_data, t3_data[k]);
                        @(posedge clk); #1;
                    end
                end
            join
            check("t3_last", last_dbg, 1);
            check("t3_done_cnt", done_cnt, t3_cnt[r]);
            check("t3_idle", state_dbg, 0);
        end

        // 4: lock holds while the other channel arms mid-transaction
        tx1.push_back(16'h0301); tx1.push_back(16'h0302);
        tx1.push_back(16'h0303); tx1.push_back(16'h8304);
        tx0.push_back(16'h0401); tx0.push_back(16'h8402);
        exp_q.push_back({1'b1, 16'h0301}); exp_q.push_back({1'b1, 16'h0302});
        exp_q.push_back({1'b1, 16'h0303}); exp_q.push_back({1'b1, 16'h8304});
        exp_q.push_back({1'b0, 16'h0401}); exp_q.push_back({1'b0, 16'h8402});
        send_pred(1, 16'h8000);
        fork
            drive_din(1);
            drive_din(0);
            begin
                cyc(3);
                pred0_valid = 1'b1; pred0_data = 16'h8000;
                @(negedge clk);
                check("t4_armed_t+4", armed_dbg, 2'b10);
                check("t4_data_t+4", dout_data, 16'h0303);
                @(posedge clk); #1;
                pred0_valid = 1'b0;
                @(negedge clk);
                check("t4_armed_t+5", armed_dbg, 2'b11);
                check("t4_sel_t+5", dout_sel, 1);
                check("t4_data_t+5", dout_data, 16'h8304);
                @(posedge clk); #1;
                @(negedge clk);
                check("t4_sel_t+6", dout_sel, 0);
                check("t4_data_t+6", dout_data, 16'h0401);
                check("t4_armed_t+6", armed_dbg, 2'b01);
                @(posedge clk); #1;
            end
        join
        cyc(1);
        check("t4_done_cnt", done_cnt, 2);
        check("t4_last", last_dbg, 0);

        // 5: backpressure 1,0,0,1 during a 3-word transaction
        dout_ready = 1'b0;
        tx0.push_back(16'h0501); tx0.push_back(16'h0502); tx0.push_back(16'h8503);
        exp_q.push_back({1'b0, 16'h0501});
        exp_q.push_back({1'b0, 16'h0502});
        exp_q.push_back({1'b0, 16'h8503});
        send_pred(0, 16'h8000);
        fork
            drive_din(0);
            begin
                cyc(1);
                dout_ready = 1'b1;
                @(negedge clk);
                check("t5_word0", dout_data, 16'h0501);
                @(posedge clk); #1;
                dout_ready = 1'b0;
                @(negedge clk);
                check("t5_stall1_valid", dout_valid, 1);
                check("t5_stall1_data", dout_data, 16'h0502);
                @(posedge clk); #1;
                @(negedge clk);
                check("t5_stall2_data", dout_data, 16'h0502);
                check("t5_stall2_cnt", done_cnt, 2);
                @(posedge clk); #1;
                dout_ready = 1'b1;
            end
        join
        check("t5_done_cnt", done_cnt, 3);
        check("t5_idle", dout_valid, 0);

        // 6: counter wrap, then reset mid-transaction
        do_reset();
        dout_ready = 1'b1;
        wrap_cnt = '{1, 2, 3, 0, 1};
        for (int k = 0; k < 5; k++) begin
            tx0.push_back(16'h8600 + 16'(k));
            exp_q.push_back({1'b0, 16'h8600 + 16'(k)});
            send_pred(0, 16'h8000);
            drive_din(0);
            check("t6_wrap_cnt", done_cnt, wrap_cnt[k]);
        end
        send_pred(1, 16'h8000);
        exp_q.push_back({1'b1, 16'h0701});
        din1_valid = 1'b1; din1_data = 16'h0701;
        cyc(2);
        din1_data = 16'h0702;
        #2;
        rst = 1'b0;
        #1;
        check("t6_async_dout_valid", dout_valid, 0);
        check("t6_async_din1_ready", din1_ready, 0);
        check("t6_async_state", state_dbg, 0);
        check("t6_async_armed", armed_dbg, 0);
        check("t6_async_done_cnt", done_cnt, 0);
        check("t6_async_pred1_ready", pred1_ready, 1);
        check("t6_async_last", last_dbg, 1);
        din1_valid = 1'b0;
        cyc(1);
        rst = 1'b1;
        cyc(2);
        check("t6_after_reset_valid", dout_valid, 0);
        check("exp_q_drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/eot_release_arbiter.md
Name: eot_release_arbiter

Overview:
- Two-requester scheduler that shares one output stream between two data channels.
- Each channel is armed by an eot word on its own predicate stream. An armed channel may then release exactly one data transaction (up to and including the din eot word) onto dout.
- Round-robin arbitration between armed channels, locked per transaction. Completed transactions are counted.
- Sits downstream of predicate generators and in front of a single shared consumer.

Parameters:
W_DIN, 16, width of din0/din1/dout data; MSB is the eot flag of the data transaction.
W_PRED, 16, width of pred0/pred1 data; MSB is the eot flag.
W_CNT, 8, width of the completed-transaction counter.

Ports:
clk  input  1  clock; all state updates on rising edge.
rst  input  1  asynchronous, active-low reset.
din0  dti.consumer  W_DIN  data channel 0.
din1  dti.consumer  W_DIN  data channel 1.
pred0  dti.consumer  W_PRED  predicate stream for channel 0.
pred1  dti.consumer  W_PRED  predicate stream for channel 1.
dout  dti.producer  W_DIN  shared output stream.
dout_sel  output  1  index of the channel currently granted; 0 when idle.
done_cnt  output  W_CNT  number of completed transactions; wraps modulo 2^W_CNT.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, armed0=armed1=0, last=1 (so channel 0 wins first tie), done_cnt=0.
  - Outputs while in reset: dout.valid=0, din0.ready=din1.ready=0, pred0.ready=pred1.ready=1, dout_sel=0.
- Predicate path, for each channel i:
  - pred_i.ready = !armed_i.
  - A handshake (valid && ready) with data[W_PRED-1]=1 sets armed_i at the next edge.
  - Non-eot predicate words are consumed and discarded.
  - While armed_i=1 the predicate stream stalls.
- Arming latency: an eot predicate accepted in cycle t makes the channel eligible for grant in cycle t+1. The earliest dout.valid is in cycle t+2, because the grant is registered.
- FSM states are IDLE, GRANT0, GRANT1.
  - IDLE: if neither channel is armed, stay.
  - IDLE: if one channel is armed, go to GRANTi.
  - IDLE: if both are armed, go to GRANT(!last).
  - GRANTi: dout.data=din_i.data, dout.valid=din_i.valid, din_i.ready=dout.ready, dout_sel=i. The other channel's din.ready=0.
  - GRANTi: on a dout handshake with data[W_DIN-1]=1 (data eot), at the next edge:
    - clear armed_i;
    - set last=i;
    - increment done_cnt;
    - go to GRANT(1-i) if armed_(1-i) is set (including one set in this same cycle), else IDLE.
  - Non-eot handshakes keep the grant (the lock holds for the whole transaction).
- Simultaneous events:
  - Predicate eot on one channel and data eot on the other in the same cycle: both take effect. The newly armed channel is granted directly.
  - Both channels arm in the same cycle: the tie is resolved by last.
- Back-to-back: a channel cannot re-arm during its own grant, because pred_i.ready=0. After a channel is released, its pred_i.ready returns to 1 in the cycle after the data eot.
- Combinational paths: dout valid/data and din ready are purely combinational from the registered state. There is no registering of data, so data passes through with zero-cycle latency.
- Reset mid-transaction: the grant is dropped immediately and arming is lost. Upstream must resend the predicate eot.
- done_cnt wraps from 2^W_CNT-1 to 0 with no saturation.

Test Plan:
1. Single channel: pred0 words 0x0001, 0x8000 → armed0 set. Then din0 words 0x0011, 0x8022 with dout.ready=1 → dout carries 0x0011, 0x8022 with dout_sel=0; first dout.valid 2 cycles after the pred eot; done_cnt=1; pred0.ready back to 1.
2. Gate closed: din1.valid=1 held with no pred1 eot for 20 cycles → dout.valid=0 and din1.ready=0 throughout.
3. Tie and round-robin: pred0 and pred1 eot in the same cycle, 2-word transactions on each din.
   - Channel 0 is granted first, then channel 1 immediately after channel 0's data eot, with no IDLE cycle.
   - Repeat: channel 0 first again. Check how last updates.
4. Lock under contention: channel 1 mid-transaction (2 of 4 words sent) when pred0 eot arrives → channel 1 completes all 4 words before dout_sel=0; no word from din0 is interleaved.
5. Backpressure: dout.ready toggling 1,0,0,1 during a 3-word din0 transaction → data is held stable while stalled, no word is dropped or duplicated, done_cnt increments once.
6. Wrap and reset: with W_CNT=2, complete 5 transactions → done_cnt sequence is 1,2,3,0,1. Then assert rst mid-transaction → dout.valid=0, armed cleared, done_cnt=0 immediately, without waiting for a clock edge.
